xlr8_pm_loader: RTL and testbench
=================================

Name: xlr8_pm_loader

Overview:
- Write-side master for the program memory write/read port (pm_ce, pm_wr, pm_addr, pm_wr_data, pm_rd_data).
- Takes a byte stream from a serial or UFM source over a valid/ready handshake and packs byte pairs little-endian into 16-bit instruction words.
- Writes each word to consecutive program-memory addresses.
- Optionally re-reads the programmed region and compares checksums, then reports done/error to the boot controller.

Parameters:
- PM_SIZE, 16, logical program memory size in KWords; depth = PM_SIZE*1024 words.
- ADDR_W, 16, width of pm_addr, start_addr and word_count.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_flash_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- start_addr  in  16  first word address, captured on accepted start
- word_count  in  16  number of words to load, captured on accepted start
- verify_en  in  1  captured on start; 1 = run readback pass after writes
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte_data this cycle
- pm_ce  out  1  program memory access enable
- pm_wr  out  1  1 = write, 0 = read (meaningful only with pm_ce)
- pm_addr  out  16  program memory word address
- pm_wr_data  out  16  write data
- pm_rd_data  in  16  read data, registered in memory, valid the cycle after a read access
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of load
- error  out  1  sticky status; cleared on next accepted start
- checksum  out  16  wrapping sum of written words; held until next start

Behaviour:
- Reset: all outputs 0; state IDLE; internal address, count and sums cleared. Asserting reset mid-load aborts immediately with pm_ce=0 the same instant; no partial word is written afterwards.
- States: IDLE, RANGE, LO, HI, WRITE, VREAD, VCMP, FIN.
- IDLE:
  - start=1 captures start_addr, word_count and verify_en.
  - Clears error and checksum, sets busy, goes to RANGE.
  - start outside IDLE is ignored.
- RANGE (1 cycle):
  - If start_addr + word_count > PM_SIZE*1024, computed at 17 bits with no wrap: set error, go to FIN with no memory access.
  - Else if word_count==0: go to FIN.
  - Else go to LO.
- LO: byte_ready=1. A transfer occurs on byte_valid & byte_ready; the byte goes to the word's low byte; next state HI.
- HI: byte_ready=1. On transfer the byte goes to the high byte; next state WRITE.
- Stall: byte_ready=0 in every state except LO/HI. No timeout; the loader waits indefinitely for bytes.
- WRITE (1 cycle):
  - pm_ce=1, pm_wr=1, pm_addr=current address, pm_wr_data=assembled word.
  - checksum += word, mod 2^16.
  - Address increments; remaining count decrements.
  - If count reaches 0: go to VREAD with address reset to start_addr when verify_en=1, otherwise to FIN. Else go to LO.
- Write rate: maximum one word per 3 cycles.
- VREAD:
  - pm_ce=1, pm_wr=0, pm_addr=current address.
  - Address increments; next state VCMP.
- VCMP:
  - pm_rd_data is valid this cycle; add it to the verify sum; decrement count.
  - If count is not 0, go to VREAD.
  - Otherwise compare verify sum with checksum: mismatch sets error. Then go to FIN.
- FIN (1 cycle): done=1, busy clears on the next edge, return to IDLE.
- pm_ce=0 in every state other than WRITE and VREAD; pm_addr and pm_wr_data hold their last value.
- Address arithmetic is 16-bit. The top valid address is PM_SIZE*1024-1; the range check ensures no wrap occurs during a load.

Test Plan:
- Basic load: reset; start_addr=0x0100, word_count=2, verify_en=0; bytes 0x0C,0x94,0x34,0x12 -> writes 0x940C@0x0100 and 0x1234@0x0101; checksum=0xA640; done pulses once; error=0.
- Verify pass: same load with verify_en=1, memory model returning the written data -> two reads at 0x0100 and 0x0101 after the writes; error=0. With the model corrupting 0x0101 to 0x1235 -> error=1.
- Range error: start_addr=0x3FFF, word_count=2, PM_SIZE=16 -> error=1, done pulses, pm_ce never asserts, byte_ready stays 0.
- Zero length: word_count=0 -> done pulses 2 cycles after start; no pm_ce; checksum=0.
- Backpressure and stall: byte_valid toggles every other cycle -> each word is written exactly once with correct data. Checksum of 0xFFFF+0x0002 is 0x0001 (wrap).
- Reset and start while busy: rst_flash_n low after the first byte -> outputs 0 immediately; a fresh load afterwards writes correctly. Separately, start pulsed while busy -> ignored; captured parameters unchanged.

Source files
------------

// File: rtl/xlr8_pm_loader.sv
// Program-memory loader: packs a little-endian byte stream into 16-bit words,
// writes them to consecutive addresses, and optionally re-reads the region
// and compares its sum against the write checksum.
module xlr8_pm_loader #(
    parameter int PM_SIZE = 16,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_flash_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              verify_en,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              pm_ce,
    output logic              pm_wr,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [15:0]       pm_wr_data,
    input  logic [15:0]       pm_rd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(PM_SIZE * 1024);

    typedef enum logic [2:0] {
        IDLE, RANGE, LO, HI, WRITE, VREAD, VCMP, FIN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_wc;
    logic              r_ven;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_cnt;
    logic [7:0]        r_lo;
    logic [15:0]       r_vsum;
    logic              r_byte_ready;
    logic              r_pm_ce;
    logic              r_pm_wr;
    logic [ADDR_W-1:0] r_pm_addr;
    logic [15:0]       r_pm_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [15:0]       r_checksum;

    // End address computed one bit wider so an overflowing range cannot wrap
    // back into the legal window.
    logic [ADDR_W:0]   w_end;
    logic              w_oob;
    logic [15:0]       w_vsum_nxt;
    logic              w_last;

    assign w_end      = {1'b0, r_start} + {1'b0, r_wc};
    assign w_oob      = (w_end > DEPTH);
    assign w_vsum_nxt = r_vsum + pm_rd_data;
    assign w_last     = (r_cnt == ADDR_W'(1));

    assign byte_ready = r_byte_ready;
    assign pm_ce      = r_pm_ce;
    assign pm_wr      = r_pm_wr;
    assign pm_addr    = r_pm_addr;
    assign pm_wr_data = r_pm_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign checksum   = r_checksum;

    // Loader FSM; every output is registered and set on entry to the state
    // that owns it, so reset drops pm_ce and byte_ready at once.
    always_ff @(posedge clk or negedge rst_flash_n) begin
        if (!rst_flash_n) begin
            r_state      <= IDLE;
            r_start      <= '0;
            r_wc         <= '0;
            r_ven        <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_lo         <= '0;
            r_vsum       <= '0;
            r_byte_ready <= 1'b0;
            r_pm_ce      <= 1'b0;
            r_pm_wr      <= 1'b0;
            r_pm_addr    <= '0;
            r_pm_wr_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_checksum   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_start    <= start_addr;
                    r_wc       <= word_count;
                    r_ven      <= verify_en;
                    r_addr     <= start_addr;
                    r_cnt      <= word_count;
                    r_error    <= 1'b0;
                    r_checksum <= '0;
                    r_busy     <= 1'b1;
                    r_state    <= RANGE;
                end
                RANGE: begin
                    if (w_oob) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end else if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_byte_ready <= 1'b1;
                        r_state      <= LO;
                    end
                end
                LO: if (byte_valid) begin
                    r_lo    <= byte_data;
                    r_state <= HI;
                end
                HI: if (byte_valid) begin
                    r_byte_ready <= 1'b0;
                    r_pm_ce      <= 1'b1;
                    r_pm_wr      <= 1'b1;
                    r_pm_addr    <= r_addr;
                    r_pm_wr_data <= {byte_data, r_lo};
                    r_state      <= WRITE;
                end
                WRITE: begin
                    r_checksum <= r_checksum + r_pm_wr_data;
                    r_addr     <= r_addr + ADDR_W'(1);
                    r_cnt      <= r_cnt - ADDR_W'(1);
                    if (!w_last) begin
                        r_pm_ce      <= 1'b0;
                        r_byte_ready <= 1'b1;
                        r_state      <= LO;
                    end else if (r_ven) begin
                        // Rewind for the readback pass; first read issues next cycle.
                        r_addr    <= r_start;
                        r_cnt     <= r_wc;
                        r_vsum    <= '0;
                        r_pm_wr   <= 1'b0;
                        r_pm_addr <= r_start;
                        r_state   <= VREAD;
                    end else begin
                        r_pm_ce <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                VREAD: begin
                    r_pm_ce <= 1'b0;
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_state <= VCMP;
                end
                VCMP: begin
                    r_vsum <= w_vsum_nxt;
                    r_cnt  <= r_cnt - ADDR_W'(1);
                    if (!w_last) begin
                        r_pm_ce   <= 1'b1;
                        r_pm_wr   <= 1'b0;
                        r_pm_addr <= r_addr;
                        r_state   <= VREAD;
                    end else begin
                        if (w_vsum_nxt != r_checksum) r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xlr8_pm_loader.sv
// Directed bench for xlr8_pm_loader with a small program-memory model.
module tb_xlr8_pm_loader;

    logic        clk = 1'b0;
    logic        rst_flash_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] word_count = '0;
    logic        verify_en = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        pm_ce;
    logic        pm_wr;
    logic [15:0] pm_addr;
    logic [15:0] pm_wr_data;
    logic [15:0] pm_rd_data = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    xlr8_pm_loader #(.PM_SIZE(16), .ADDR_W(16)) dut (
        .clk(clk), .rst_flash_n(rst_flash_n), .start(start),
        .start_addr(start_addr), .word_count(word_count), .verify_en(verify_en),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .pm_ce(pm_ce), .pm_wr(pm_wr), .pm_addr(pm_addr), .pm_wr_data(pm_wr_data),
        .pm_rd_data(pm_rd_data), .busy(busy), .done(done), .error(error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, optional corruption of word 0x0101.
    logic [15:0] mem [0:16383];
    logic        corrupt = 1'b0;
    always @(posedge clk) begin
        if (pm_ce && pm_wr) mem[pm_addr[13:0]] <= pm_wr_data;
        if (pm_ce && !pm_wr)
            pm_rd_data <= mem[pm_addr[13:0]] + ((corrupt && pm_addr == 16'h0101) ? 16'd1 : 16'd0);
    end

    // Activity log sampled mid-cycle.
    logic [15:0] wa[$], wd[$], ra[$];
    int ce_cnt, done_cnt, br_cnt;
    always @(negedge clk) begin
        if (pm_ce && pm_wr) begin wa.push_back(pm_addr); wd.push_back(pm_wr_data); end
        if (pm_ce && !pm_wr) ra.push_back(pm_addr);
        if (pm_ce) ce_cnt++;
        if (done) done_cnt++;
        if (byte_ready) br_cnt++;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        wa.delete(); wd.delete(); ra.delete();
        ce_cnt = 0; done_cnt = 0; br_cnt = 0;
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] n, input logic v);
        @(negedge clk);
        start = 1'b1; start_addr = a; word_count = n; verify_en = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer bytes (optionally only every other cycle) until done pulses.
    task automatic feed(input string tag, input logic [7:0] bq[$], input bit toggle);
        int idx = 0;
        int cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            @(negedge clk);
            if (idx < bq.size() && (!toggle || cyc % 2 == 0)) begin
                byte_valid = 1'b1; byte_data = bq[idx];
            end else begin
                byte_valid = 1'b0;
            end
            if (byte_valid && byte_ready) idx++;
            cyc++;
        end
        byte_valid = 1'b0;
        chk({tag, "_no_timeout"}, 32'(done_cnt > 0), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] bq[$];
        int n;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_ce", 32'(pm_ce), 0);
        chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_csum", 32'(checksum), 0);
        @(negedge clk); rst_flash_n = 1'b1;

        // Basic load
        clr_log();
        do_start(16'h0100, 16'd2, 1'b0);
        bq = '{8'h0C, 8'h94, 8'h34, 8'h12};
        feed("basic", bq, 1'b0);
        chk("basic_nwr", 32'(wa.size()), 2);
        if (wa.size() == 2) begin
            chk("basic_a0", 32'(wa[0]), 32'h0100);
            chk("basic_d0", 32'(wd[0]), 32'h940C);
            chk("basic_a1", 32'(wa[1]), 32'h0101);
            chk("basic_d1", 32'(wd[1]), 32'h1234);
        end
        chk("basic_csum", 32'(checksum), 32'hA640);
        chk("basic_done", done_cnt, 1);
        chk("basic_err", 32'(error), 0);
        chk("basic_busy", 32'(busy), 0);
        chk("basic_reads", 32'(ra.size()), 0);

        // Verify pass
        clr_log();
        do_start(16'h0100, 16'd2, 1'b1);
        feed("vpass", bq, 1'b0);
        chk("vpass_nrd", 32'(ra.size()), 2);
        if (ra.size() == 2) begin
            chk("vpass_r0", 32'(ra[0]), 32'h0100);
            chk("vpass_r1", 32'(ra[1]), 32'h0101);
        end
        chk("vpass_nwr", 32'(wa.size()), 2);
        chk("vpass_err", 32'(error), 0);
        chk("vpass_done", done_cnt, 1);

        // Verify with corrupted readback
        clr_log();
        corrupt = 1'b1;
        do_start(16'h0100, 16'd2, 1'b1);
        feed("vfail", bq, 1'b0);
        corrupt = 1'b0;
        chk("vfail_err", 32'(error), 1);
        chk("vfail_csum", 32'(checksum), 32'hA640);

        // Out of range: 0x3FFF + 2 > 0x4000
        clr_log();
        do_start(16'h3FFF, 16'd2, 1'b0);
        feed("range", bq, 1'b0);
        chk("range_err", 32'(error), 1);
        chk("range_done", done_cnt, 1);
        chk("range_ce", ce_cnt, 0);
        chk("range_ready", br_cnt, 0);

        // Exactly reaching the top of memory is legal; also clears error
        clr_log();
        do_start(16'h3FFE, 16'd2, 1'b0);
        feed("top", bq, 1'b0);
        chk("top_err", 32'(error), 0);
        chk("top_nwr", 32'(wa.size()), 2);
        if (wa.size() == 2) chk("top_a1", 32'(wa[1]), 32'h3FFF);

        // Zero length: done two cycles after start
        clr_log();
        do_start(16'h0010, 16'd0, 1'b0);
        chk("zero_done_c1", 32'(done), 0);
        @(negedge clk);
        chk("zero_done_c2", 32'(done), 1);
        @(negedge clk);
        chk("zero_done_c3", 32'(done), 0);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_ce", ce_cnt, 0);
        chk("zero_csum", 32'(checksum), 0);

        // Backpressure and checksum wrap
        clr_log();
        do_start(16'h0200, 16'd2, 1'b0);
        bq = '{8'hFF, 8'hFF, 8'h02, 8'h00};
        feed("bp", bq, 1'b1);
        chk("bp_nwr", 32'(wa.size()), 2);
        if (wa.size() == 2) begin
            chk("bp_d0", 32'(wd[0]), 32'hFFFF);
            chk("bp_d1", 32'(wd[1]), 32'h0002);
            chk("bp_a1", 32'(wa[1]), 32'h0201);
        end
        chk("bp_csum", 32'(checksum), 32'h0001);

        // Reset after the first byte aborts the load
        clr_log();
        do_start(16'h0280, 16'd2, 1'b0);
        n = 0;
        while (!byte_ready && n < 10) begin @(negedge clk); n++; end
        chk("abort_reach_lo", 32'(byte_ready), 1);
        byte_valid = 1'b1; byte_data = 8'h77;
        @(negedge clk);
        byte_valid = 1'b0;
        #2 rst_flash_n = 1'b0;
        #1;
        chk("abort_ce", 32'(pm_ce), 0);
        chk("abort_ready", 32'(byte_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        rst_flash_n = 1'b1;
        chk("abort_nwr", 32'(wa.size()), 0);
        clr_log();
        do_start(16'h0300, 16'd1, 1'b0);
        bq = '{8'hAA, 8'h55};
        feed("fresh", bq, 1'b0);
        chk("fresh_nwr", 32'(wa.size()), 1);
        if (wa.size() == 1) begin
            chk("fresh_a0", 32'(wa[0]), 32'h0300);
            chk("fresh_d0", 32'(wd[0]), 32'h55AA);
        end

        // Start while busy is ignored
        clr_log();
        do_start(16'h0400, 16'd1, 1'b0);
        @(negedge clk);
        start = 1'b1; start_addr = 16'h0500; word_count = 16'd5; verify_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bq = '{8'h11, 8'h22};
        feed("busy", bq, 1'b0);
        chk("busy_nwr", 32'(wa.size()), 1);
        if (wa.size() == 1) begin
            chk("busy_a0", 32'(wa[0]), 32'h0400);
            chk("busy_d0", 32'(wd[0]), 32'h2211);
        end
        chk("busy_nrd", 32'(ra.size()), 0);
        chk("busy_done", done_cnt, 1);
        chk("busy_csum", 32'(checksum), 32'h2211);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
